// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver for the rs232_tx stream.
// The line is double-flopped, the start bit is confirmed at its midpoint, and
// every later bit is sampled one full bit period after the previous sample.
// out_valid and out_frame_err are one-cycle pulses with no backpressure.
module uart_rx #(
  parameter int clocks_per_bit = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_frame_err,
  output logic       out_busy
);

  localparam int cw = $clog2(clocks_per_bit);
  localparam int half = clocks_per_bit / 2;
  localparam logic [cw-1:0] last_cycle = cw'(clocks_per_bit - 1);
  localparam logic [cw-1:0] half_cycle = cw'(half - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // state is kept as a named enum so checkers can bind to it directly
  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          rx;
  logic [cw-1:0] cycle_count;
  logic [2:0]    bit_count;
  logic [7:0]    shift;

  assign rx       = sync2;
  assign out_busy = (state != S_IDLE);

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= in_rx;
      sync2 <= sync1;
    end
  end

  // Frame FSM: start-bit qualification, data shift, stop check and break hold
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cycle_count   <= '0;
      bit_count     <= '0;
      shift         <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_frame_err <= 1'b0;
    end else begin
      out_valid     <= 1'b0;
      out_frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          cycle_count <= '0;
          if (!rx) state <= S_START;
        end
        S_START: begin
          cycle_count <= cycle_count + 1'b1;
          if (cycle_count == half_cycle) begin
            if (rx) begin
              // line came back high before mid start bit: treat as a glitch
              state <= S_IDLE;
            end else begin
              state       <= S_DATA;
              cycle_count <= '0;
              bit_count   <= '0;
            end
          end
        end
        S_DATA: begin
          if (cycle_count == last_cycle) begin
            cycle_count <= '0;
            shift       <= {rx, shift[7:1]};
            bit_count   <= bit_count + 3'd1;
            if (bit_count == 3'd7) state <= S_STOP;
          end else begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        S_STOP: begin
          if (cycle_count == last_cycle) begin
            cycle_count <= '0;
            if (rx) begin
              // leaving at mid stop bit lets a back-to-back start bit be caught
              out_data  <= shift;
              out_valid <= 1'b1;
              state     <= S_IDLE;
            end else begin
              out_frame_err <= 1'b1;
              state         <= S_BREAK;
            end
          end else begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        S_BREAK: begin
          // a held-low line reports once, then waits for idle
          if (rx) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames into two receivers (N=4 and N=7) and checks
// received bytes, pulse timing, glitch rejection, framing errors and reset.
module tb_uart_rx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUTs ----------------
  logic       in_rx4 = 1'b1;
  logic [7:0] out_data4;
  logic       out_valid4, out_frame_err4, out_busy4;
  logic       in_rx7 = 1'b1;
  logic [7:0] out_data7;
  logic       out_valid7, out_frame_err7, out_busy7;

  uart_rx #(.clocks_per_bit(4)) dut4 (
    .clk(clk), .reset(reset), .in_rx(in_rx4),
    .out_data(out_data4), .out_valid(out_valid4),
    .out_frame_err(out_frame_err4), .out_busy(out_busy4)
  );

  uart_rx #(.clocks_per_bit(7)) dut7 (
    .clk(clk), .reset(reset), .in_rx(in_rx7),
    .out_data(out_data7), .out_valid(out_valid7),
    .out_frame_err(out_frame_err7), .out_busy(out_busy7)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q4[$];
  logic [7:0] exp_q7[$];
  int         lat_q4[$];
  int         lat_q7[$];
  int         err_exp4 = 0;
  int         err_cnt4 = 0;
  int         err_cnt7 = 0;
  int         valid_cnt4 = 0;
  int         valid_cnt7 = 0;
  logic [7:0] last_good4 = 8'h00;

  // receiver monitor, N=4
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid4 || out_frame_err4)
        check("exclusive4", {31'd0, out_valid4 & out_frame_err4}, 32'd0);
      if (out_frame_err4) err_cnt4++;
      if (out_valid4) begin
        valid_cnt4++;
        if (exp_q4.size() == 0) begin
          check("unexpected_valid4", 32'd1, 32'd0);
        end else begin
          logic [7:0] e;
          int l;
          e = exp_q4.pop_front();
          l = lat_q4.pop_front();
          check("data4", {24'd0, out_data4}, {24'd0, e});
          check("latency4", cyc, l);
          last_good4 = e;
        end
      end
    end
  end

  // receiver monitor, N=7
  always @(negedge clk) begin
    if (!reset) begin
      if (out_frame_err7) err_cnt7++;
      if (out_valid7) begin
        valid_cnt7++;
        if (exp_q7.size() == 0) begin
          check("unexpected_valid7", 32'd1, 32'd0);
        end else begin
          logic [7:0] e;
          int l;
          e = exp_q7.pop_front();
          l = lat_q7.pop_front();
          check("data7", {24'd0, out_data7}, {24'd0, e});
          check("latency7", cyc, l);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) in_rx4 = v;
    else            in_rx7 = v;
  endtask

  // One 8N1 frame; a good stop bit queues the byte and its pulse cycle.
  task automatic send_byte(input int which, input logic [7:0] b, input bit good_stop);
    int n;
    n = (which == 0) ? 4 : 7;
    if (good_stop) begin
      // start bit captured by sync1 at edge cyc+1; pulse seen after 2+H+9N more
      if (which == 0) begin
        exp_q4.push_back(b);
        lat_q4.push_back(cyc + 3 + n / 2 + 9 * n);
      end else begin
        exp_q7.push_back(b);
        lat_q7.push_back(cyc + 3 + n / 2 + 9 * n);
      end
    end else begin
      err_exp4++;
    end
    set_line(which, 1'b0);
    tick(n);
    for (int i = 0; i < 8; i++) begin
      set_line(which, b[i]);
      tick(n);
    end
    set_line(which, good_stop ? 1'b1 : 1'b0);
    tick(n);
  endtask

  task automatic wait_drain(input int which);
    for (int i = 0; i < 2000; i++) begin
      if (which == 0 && exp_q4.size() == 0) break;
      if (which == 1 && exp_q7.size() == 0) break;
      tick(1);
    end
    check(which == 0 ? "drain4" : "drain7",
          which == 0 ? exp_q4.size() : exp_q7.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] cut;
    bit busy_seen;
    int v0;

    // reset state
    tick(3);
    check("rst_data", {24'd0, out_data4}, 32'd0);
    check("rst_valid", {31'd0, out_valid4}, 32'd0);
    check("rst_err", {31'd0, out_frame_err4}, 32'd0);
    check("rst_busy", {31'd0, out_busy4}, 32'd0);
    reset = 1'b0;
    tick(5);

    // single frame
    send_byte(0, 8'h55, 1'b1);
    tick(4);
    wait_drain(0);

    // back-to-back frames, no idle gap
    send_byte(0, 8'hA5, 1'b1);
    send_byte(0, 8'h3C, 1'b1);
    wait_drain(0);
    tick(5);

    // one-cycle glitch
    in_rx4 = 1'b0;
    tick(1);
    in_rx4 = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_busy4) busy_seen = 1'b1;
      tick(1);
    end
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_idle", {31'd0, out_busy4}, 32'd0);
    send_byte(0, 8'h81, 1'b1);
    tick(4);
    wait_drain(0);

    // stop bit low, line held low, then recovery
    send_byte(0, 8'h7E, 1'b0);
    tick(30);
    check("break_busy", {31'd0, out_busy4}, 32'd1);
    check("break_data_hold", {24'd0, out_data4}, {24'd0, last_good4});
    check("break_err_count", err_cnt4, err_exp4);
    in_rx4 = 1'b1;
    tick(5);
    check("break_exit_busy", {31'd0, out_busy4}, 32'd0);
    send_byte(0, 8'h12, 1'b1);
    tick(4);
    wait_drain(0);

    // reset during data bit 4 of a 0x5A frame (bit 4 is 1)
    cut = 8'h5A;
    in_rx4 = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      in_rx4 = cut[i];
      tick(4);
    end
    in_rx4 = cut[4];
    tick(2);
    reset = 1'b1;
    tick(1);
    check("midrst_data", {24'd0, out_data4}, 32'd0);
    check("midrst_valid", {31'd0, out_valid4}, 32'd0);
    check("midrst_err", {31'd0, out_frame_err4}, 32'd0);
    check("midrst_busy", {31'd0, out_busy4}, 32'd0);
    reset = 1'b0;
    in_rx4 = 1'b1;
    tick(50);
    check("midrst_idle_busy", {31'd0, out_busy4}, 32'd0);
    send_byte(0, 8'hC3, 1'b1);
    tick(4);
    wait_drain(0);

    // loopback-style sweep of all byte values, N=4
    v0 = valid_cnt4;
    for (int v = 0; v < 256; v++) send_byte(0, v[7:0], 1'b1);
    tick(4);
    wait_drain(0);
    check("sweep4_count", valid_cnt4 - v0, 32'd256);

    // same sweep, N=7
    for (int v = 0; v < 256; v++) send_byte(1, v[7:0], 1'b1);
    tick(4);
    wait_drain(1);
    check("sweep7_count", valid_cnt7, 32'd256);

    // final error tallies
    check("final_err4", err_cnt4, err_exp4);
    check("final_err7", err_cnt7, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
